// File: rtl/fifo_write_scheduler.sv
// fifo_write_scheduler
//   Captures samples from a slow, asynchronous source into a one-entry hold
//   register and serialises them LSB-first as byte writes into a FIFO.
//   After every SYNC_PERIOD captured samples a sync frame carrying SYNC_WORD
//   is inserted. Samples arriving while the hold register is still occupied
//   are dropped and counted.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   enable        gates acceptance of new samples
//   sample_valid  sample-done level from the source domain (asynchronous)
//   sample_data   sample value, stable while sample_valid is high
//   fifo_full     FIFO full flag (clk domain)
//   clear_stats   one-cycle pulse clearing drop_count and overflow
//   fifo_wr_en    registered byte write strobe
//   fifo_wr_data  registered byte value
//   busy          high while a frame is being sent
//   drop_count    number of lost samples, saturating
//   overflow      sticky flag, set on any drop
module fifo_write_scheduler #(
  parameter int                   DATA_SIZE   = 24,
  parameter int                   SYNC_PERIOD = 127,
  parameter logic [DATA_SIZE-1:0] SYNC_WORD   = 24'hAAFF00,
  parameter int                   DROP_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 sample_valid,
  input  logic [DATA_SIZE-1:0] sample_data,
  input  logic                 fifo_full,
  input  logic                 clear_stats,
  output logic                 fifo_wr_en,
  output logic [7:0]           fifo_wr_data,
  output logic                 busy,
  output logic [DROP_W-1:0]    drop_count,
  output logic                 overflow
);

  localparam int BYTES = DATA_SIZE / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] PERIOD   = CNT_W'(SYNC_PERIOD);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state, state_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic                 wr_en_next;
  logic [7:0]           wr_data_next;

  logic                 s0, s1, s2;
  logic                 sample_evt;

  logic [DATA_SIZE-1:0] hold_data;
  logic                 hold_valid;
  logic [DATA_SIZE-1:0] frame_data;
  logic                 frame_is_sync;
  logic                 sync_pending;
  logic [CNT_W-1:0]     sample_cnt;
  logic                 cnt_hit;

  logic                 start_sync, start_sample;
  logic                 capture, drop;
  logic [DATA_SIZE-1:0] cur_word;
  logic [7:0]           cur_byte;

  assign sample_evt = s1 & ~s2;
  assign cnt_hit    = (sample_cnt == PERIOD);

  // Sync frames take precedence over a held sample.
  assign start_sync   = (state == IDLE) && sync_pending;
  assign start_sample = (state == IDLE) && !sync_pending && hold_valid;

  // A sample frame starting this cycle frees the hold register, so an event
  // arriving on the same cycle is captured rather than dropped.
  assign capture = sample_evt && enable && (!hold_valid || start_sample);
  assign drop    = sample_evt && enable && hold_valid && !start_sample;

  assign cur_word = frame_is_sync ? SYNC_WORD : frame_data;
  assign cur_byte = cur_word[{idx, 3'b000} +: 8];

  assign busy = (state == SEND);

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    wr_en_next   = 1'b0;
    wr_data_next = fifo_wr_data;
    case (state)
      IDLE: begin
        if (sync_pending || hold_valid) begin
          state_next = SEND;
          idx_next   = '0;
        end
      end
      SEND: begin
        if (!fifo_full) begin
          wr_en_next   = 1'b1;
          wr_data_next = cur_byte;
          if (idx == LAST_IDX) begin
            state_next = IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      fifo_wr_en    <= 1'b0;
      fifo_wr_data  <= '0;
      s0            <= 1'b0;
      s1            <= 1'b0;
      s2            <= 1'b0;
      hold_data     <= '0;
      hold_valid    <= 1'b0;
      frame_data    <= '0;
      frame_is_sync <= 1'b0;
      sync_pending  <= 1'b0;
      sample_cnt    <= '0;
      drop_count    <= '0;
      overflow      <= 1'b0;
    end else begin
      s0 <= sample_valid;
      s1 <= s0;
      s2 <= s1;

      state        <= state_next;
      idx          <= idx_next;
      fifo_wr_en   <= wr_en_next;
      fifo_wr_data <= wr_data_next;

      if (start_sync) begin
        frame_is_sync <= 1'b1;
      end else if (start_sample) begin
        frame_is_sync <= 1'b0;
        frame_data    <= hold_data;
      end

      if (capture) begin
        hold_data  <= sample_data;
        hold_valid <= 1'b1;
      end else if (start_sample) begin
        hold_valid <= 1'b0;
      end

      // The period check runs one cycle after the capture that completes it,
      // so the sample ending a period is framed before its sync frame.
      if (cnt_hit) begin
        sync_pending <= 1'b1;
        sample_cnt   <= capture ? CNT_W'(1) : '0;
      end else begin
        if (start_sync) begin
          sync_pending <= 1'b0;
        end
        if (capture) begin
          sample_cnt <= sample_cnt + 1'b1;
        end
      end

      if (clear_stats) begin
        drop_count <= '0;
        overflow   <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_scheduler.sv
// Testbench for fifo_write_scheduler: three instances (defaults, a short
// sync period, a narrow drop counter) share stimulus; a monitor records the
// byte streams, and each scenario task compares them against expectations
// built from the sample values it sent.
module tb_fifo_write_scheduler;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        sample_valid;
  logic [23:0] sample_data;
  logic        fifo_full;
  logic        clear_stats;

  logic        dut_wr_en, s_wr_en, d_wr_en;
  logic [7:0]  dut_wr_data, s_wr_data, d_wr_data;
  logic        dut_busy, s_busy, d_busy;
  logic [15:0] dut_drop, s_drop;
  logic [1:0]  d_drop;
  logic        dut_ovf, s_ovf, d_ovf;

  int checks = 0;
  int errors = 0;

  fifo_write_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .fifo_full(fifo_full), .clear_stats(clear_stats),
    .fifo_wr_en(dut_wr_en), .fifo_wr_data(dut_wr_data), .busy(dut_busy),
    .drop_count(dut_drop), .overflow(dut_ovf)
  );

  fifo_write_scheduler #(.SYNC_PERIOD(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .fifo_full(fifo_full), .clear_stats(clear_stats),
    .fifo_wr_en(s_wr_en), .fifo_wr_data(s_wr_data), .busy(s_busy),
    .drop_count(s_drop), .overflow(s_ovf)
  );

  fifo_write_scheduler #(.DROP_W(2)) dut_d (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .fifo_full(fifo_full), .clear_stats(clear_stats),
    .fifo_wr_en(d_wr_en), .fifo_wr_data(d_wr_data), .busy(d_busy),
    .drop_count(d_drop), .overflow(d_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: cycle count, full flag as seen by each edge, byte streams.
  int         cyc = 0;
  logic       full_q = 1'b0;
  int         viol = 0;
  int         busy_cnt = 0;
  logic [7:0] mon_q[$];
  int         stamp_q[$];
  logic [7:0] mon_s_q[$];

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    full_q <= fifo_full;
  end

  always @(negedge clk) begin
    if (dut_wr_en) begin
      mon_q.push_back(dut_wr_data);
      stamp_q.push_back(cyc);
      if (full_q) viol <= viol + 1;
    end
    if (s_wr_en) mon_s_q.push_back(s_wr_data);
    if (dut_busy) busy_cnt <= busy_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    enable       = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    fifo_full    = 1'b0;
    clear_stats  = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic send_sample(input logic [23:0] data, input int lo);
    sample_data  = data;
    sample_valid = 1'b1;
    wait_cycles(4);
    sample_valid = 1'b0;
    wait_cycles(lo);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    enable       = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 24'hFFFFFF;
    fifo_full    = 1'b0;
    clear_stats  = 1'b0;
    wait_cycles(6);
    checks++;
    if ({dut_wr_en, dut_wr_data, dut_busy, dut_drop, dut_ovf} !== 27'd0) begin
      errors++;
      $display("FAIL reset_dut: got %0h expected 0", {dut_wr_en, dut_wr_data, dut_busy, dut_drop, dut_ovf});
    end
    checks++;
    if ({s_wr_en, s_wr_data, s_busy, s_drop, s_ovf, d_wr_en, d_wr_data, d_busy, d_drop, d_ovf} !== 40'd0) begin
      errors++;
      $display("FAIL reset_variants: got %0h expected 0",
               {s_wr_en, s_wr_data, s_busy, s_drop, s_ovf, d_wr_en, d_wr_data, d_busy, d_drop, d_ovf});
    end
    do_reset();
  endtask

  task automatic test_single();
    int base, bbase, k;
    do_reset();
    base  = mon_q.size();
    bbase = busy_cnt;
    k     = cyc + 1;
    send_sample(24'h123456, 12);
    checks++;
    if (mon_q.size() != base + 3) begin
      errors++;
      $display("FAIL single_count: got %0d bytes expected 3", mon_q.size() - base);
    end else begin
      checks++;
      if ({mon_q[base], mon_q[base+1], mon_q[base+2]} !== 24'h563412) begin
        errors++;
        $display("FAIL single_bytes: got %h expected 563412", {mon_q[base], mon_q[base+1], mon_q[base+2]});
      end
      checks++;
      if (stamp_q[base] - k > 4) begin
        errors++;
        $display("FAIL single_latency: got %0d cycles expected at most 4", stamp_q[base] - k);
      end
      checks++;
      if (stamp_q[base+2] - stamp_q[base] != 2) begin
        errors++;
        $display("FAIL single_consecutive: got span %0d expected 2", stamp_q[base+2] - stamp_q[base]);
      end
    end
    checks++;
    if (busy_cnt - bbase != 3) begin
      errors++;
      $display("FAIL single_busy: got %0d cycles expected 3", busy_cnt - bbase);
    end
  endtask

  task automatic test_sync_period();
    logic [7:0]  exp_s[$];
    logic [7:0]  exp_d[$];
    logic [23:0] data;
    logic [23:0] sw;
    int base, base_s, bad;
    do_reset();
    base   = mon_q.size();
    base_s = mon_s_q.size();
    sw     = 24'hAAFF00;
    for (int i = 1; i <= 9; i++) begin
      data = 24'($urandom);
      for (int b = 0; b < 3; b++) begin
        exp_s.push_back(data[8*b +: 8]);
        exp_d.push_back(data[8*b +: 8]);
      end
      if (i % 4 == 0)
        for (int b = 0; b < 3; b++) exp_s.push_back(sw[8*b +: 8]);
      send_sample(data, 12);
    end
    wait_cycles(10);
    checks++;
    if (mon_s_q.size() - base_s != exp_s.size()) begin
      errors++;
      $display("FAIL sync_stream_len: got %0d expected %0d", mon_s_q.size() - base_s, exp_s.size());
    end else begin
      bad = 0;
      for (int i = 0; i < exp_s.size(); i++)
        if (mon_s_q[base_s+i] !== exp_s[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL sync_stream_bytes: got %0d wrong bytes expected 0", bad);
      end
    end
    checks++;
    if (mon_q.size() - base != exp_d.size()) begin
      errors++;
      $display("FAIL nosync_stream_len: got %0d expected %0d", mon_q.size() - base, exp_d.size());
    end
  endtask

  task automatic test_backpressure();
    int base, vbase, s0;
    do_reset();
    base  = mon_q.size();
    vbase = viol;
    sample_data  = 24'hABCDEF;
    sample_valid = 1'b1;
    for (int i = 0; i < 20 && mon_q.size() == base; i++) wait_cycles(1);
    checks++;
    if (mon_q.size() != base + 1) begin
      errors++;
      $display("FAIL bp_first: got %0d bytes expected 1", mon_q.size() - base);
    end
    fifo_full = 1'b1;
    wait_cycles(5);
    fifo_full    = 1'b0;
    sample_valid = 1'b0;
    wait_cycles(6);
    checks++;
    if (mon_q.size() != base + 3) begin
      errors++;
      $display("FAIL bp_count: got %0d bytes expected 3", mon_q.size() - base);
    end else begin
      s0 = stamp_q[base];
      checks++;
      if ({mon_q[base], mon_q[base+1], mon_q[base+2]} !== 24'hEFCDAB) begin
        errors++;
        $display("FAIL bp_bytes: got %h expected efcdab", {mon_q[base], mon_q[base+1], mon_q[base+2]});
      end
      checks++;
      if (stamp_q[base+1] != s0 + 6 || stamp_q[base+2] != s0 + 7) begin
        errors++;
        $display("FAIL bp_timing: got offsets %0d,%0d expected 6,7", stamp_q[base+1] - s0, stamp_q[base+2] - s0);
      end
    end
    checks++;
    if (viol != vbase) begin
      errors++;
      $display("FAIL bp_strobe_while_full: got %0d expected 0", viol - vbase);
    end
  endtask

  task automatic test_drops();
    logic [23:0] a, b, got, gotb;
    int base;
    do_reset();
    base = mon_q.size();
    a = 24'h0A0B0C;
    b = 24'h1A1B1C;
    fifo_full = 1'b1;
    send_sample(a, 6);
    send_sample(b, 6);
    for (int i = 0; i < 3; i++) send_sample(24'($urandom), 6);
    checks++;
    if (dut_drop !== 16'd3 || dut_ovf !== 1'b1) begin
      errors++;
      $display("FAIL drop_three: got %0d/%0b expected 3/1", dut_drop, dut_ovf);
    end
    for (int i = 0; i < 2; i++) send_sample(24'($urandom), 6);
    checks++;
    if (dut_drop !== 16'd5 || d_drop !== 2'd3 || d_ovf !== 1'b1) begin
      errors++;
      $display("FAIL drop_saturate: got %0d,%0d,%0b expected 5,3,1", dut_drop, d_drop, d_ovf);
    end
    clear_stats = 1'b1;
    wait_cycles(1);
    clear_stats = 1'b0;
    checks++;
    if (dut_drop !== 16'd0 || dut_ovf !== 1'b0 || d_drop !== 2'd0) begin
      errors++;
      $display("FAIL drop_clear: got %0d,%0b,%0d expected 0,0,0", dut_drop, dut_ovf, d_drop);
    end
    // Drop lands on the third edge after valid rises; clear that same edge.
    sample_valid = 1'b1;
    wait_cycles(2);
    clear_stats = 1'b1;
    wait_cycles(1);
    clear_stats = 1'b0;
    checks++;
    if (dut_drop !== 16'd0 || dut_ovf !== 1'b0) begin
      errors++;
      $display("FAIL drop_clear_wins: got %0d/%0b expected 0/0", dut_drop, dut_ovf);
    end
    sample_valid = 1'b0;
    wait_cycles(4);
    checks++;
    if (mon_q.size() != base) begin
      errors++;
      $display("FAIL drop_stuck_full: got %0d bytes expected 0", mon_q.size() - base);
    end
    fifo_full = 1'b0;
    wait_cycles(12);
    checks++;
    if (mon_q.size() != base + 6) begin
      errors++;
      $display("FAIL drop_drain_count: got %0d expected 6", mon_q.size() - base);
    end else begin
      got  = {mon_q[base+2], mon_q[base+1], mon_q[base]};
      gotb = {mon_q[base+5], mon_q[base+4], mon_q[base+3]};
      checks++;
      if (got !== a || gotb !== b) begin
        errors++;
        $display("FAIL drop_drain_data: got %h %h expected %h %h", got, gotb, a, b);
      end
    end
  endtask

  task automatic test_enable();
    int base;
    logic [23:0] got;
    do_reset();
    base   = mon_q.size();
    enable = 1'b0;
    send_sample(24'h445566, 8);
    send_sample(24'h778899, 8);
    checks++;
    if (mon_q.size() != base || dut_drop !== 16'd0 || dut_busy !== 1'b0) begin
      errors++;
      $display("FAIL enable_low: got %0d bytes drop %0d expected 0 bytes drop 0", mon_q.size() - base, dut_drop);
    end
    enable       = 1'b1;
    sample_data  = 24'hC0FFEE;
    sample_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 3) sample_valid = 1'b0;
      if (mon_q.size() > base) enable = 1'b0;
      wait_cycles(1);
    end
    checks++;
    if (mon_q.size() != base + 3) begin
      errors++;
      $display("FAIL enable_midframe_count: got %0d expected 3", mon_q.size() - base);
    end else begin
      got = {mon_q[base+2], mon_q[base+1], mon_q[base]};
      checks++;
      if (got !== 24'hC0FFEE) begin
        errors++;
        $display("FAIL enable_midframe_data: got %h expected c0ffee", got);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    logic [23:0] got;
    do_reset();
    base = mon_q.size();
    sample_data  = 24'h654321;
    sample_valid = 1'b1;
    for (int i = 0; i < 30 && mon_q.size() < base + 2; i++) begin
      if (i == 3) sample_valid = 1'b0;
      wait_cycles(1);
    end
    sample_valid = 1'b0;
    rst_n = 1'b0;
    wait_cycles(1);
    checks++;
    if (mon_q.size() != base + 2 || {dut_wr_en, dut_wr_data, dut_busy, dut_drop, dut_ovf} !== 27'd0) begin
      errors++;
      $display("FAIL midreset_state: got %0d bytes outputs %h expected 2 bytes outputs 0",
               mon_q.size() - base, {dut_wr_en, dut_wr_data, dut_busy, dut_drop, dut_ovf});
    end
    wait_cycles(1);
    rst_n = 1'b1;
    wait_cycles(10);
    checks++;
    if (mon_q.size() != base + 2) begin
      errors++;
      $display("FAIL midreset_no_strobes: got %0d bytes expected 2", mon_q.size() - base);
    end
    send_sample(24'h9ABCDE, 10);
    checks++;
    if (mon_q.size() != base + 5) begin
      errors++;
      $display("FAIL midreset_next_count: got %0d expected 3", mon_q.size() - base - 2);
    end else begin
      got = {mon_q[base+4], mon_q[base+3], mon_q[base+2]};
      checks++;
      if (got !== 24'h9ABCDE) begin
        errors++;
        $display("FAIL midreset_next_data: got %h expected 9abcde", got);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]  exp_q[$];
    logic [23:0] data;
    int base, vbase, bad, target;
    do_reset();
    base  = mon_q.size();
    vbase = viol;
    for (int n = 0; n < 25; n++) begin
      data = 24'($urandom);
      for (int b = 0; b < 3; b++) exp_q.push_back(data[8*b +: 8]);
      target = base + exp_q.size();
      sample_data = data;
      for (int i = 0; i < 300; i++) begin
        fifo_full    = ($urandom_range(0, 2) == 0);
        sample_valid = (i < 4);
        wait_cycles(1);
        if (i >= 6 && mon_q.size() >= target) break;
      end
      fifo_full    = 1'b0;
      sample_valid = 1'b0;
    end
    wait_cycles(10);
    checks++;
    if (mon_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL random_len: got %0d expected %0d", mon_q.size() - base, exp_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++)
        if (mon_q[base+i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random_bytes: got %0d wrong bytes expected 0", bad);
      end
    end
    checks++;
    if (viol != vbase || dut_drop !== 16'd0) begin
      errors++;
      $display("FAIL random_full_rule: got %0d strobes after full, drop %0d expected 0, 0", viol - vbase, dut_drop);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sync_period();
    test_backpressure();
    test_drops();
    test_enable();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
